// File: rtl/byte_sum_accumulator_if.sv
// Byte-stream / result handshake bundle for byte_sum_accumulator.
interface byte_sum_accumulator_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned SUM_WIDTH  = 16,
  parameter int unsigned LEN_WIDTH  = 16
);
  logic                  start;
  logic [LEN_WIDTH-1:0]  length;
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  in_ready;
  logic                  sum_valid;
  logic [SUM_WIDTH-1:0]  sum_out;
  logic                  overflow;
  logic                  sum_ack;
  logic                  busy;
  logic [LEN_WIDTH-1:0]  count;

  modport master (
    output start, length, in_valid, in_data, sum_ack,
    input  in_ready, sum_valid, sum_out, overflow, busy, count
  );

  modport slave (
    input  start, length, in_valid, in_data, sum_ack,
    output in_ready, sum_valid, sum_out, overflow, busy, count
  );
endinterface

// File: rtl/byte_sum_accumulator.sv
// Length-framed byte accumulator: sums zero-extended bytes into a wrapping
// register with a sticky carry flag, then holds the result until acknowledged.
module byte_sum_accumulator #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned SUM_WIDTH  = 16,
  parameter int unsigned LEN_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  byte_sum_accumulator_if.slave   bus
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam int unsigned EXT_WIDTH = SUM_WIDTH + 1;

  logic [1:0]           r_state;
  logic [1:0]           w_state_nxt;
  logic [SUM_WIDTH-1:0] r_acc;
  logic [LEN_WIDTH-1:0] r_count;
  logic [LEN_WIDTH-1:0] r_len;
  logic                 r_ovf;
  logic                 r_in_ready;
  logic                 r_sum_valid;
  logic                 r_busy;

  logic                 w_xfer;
  logic                 w_last;
  logic [LEN_WIDTH-1:0] w_count_inc;
  logic [EXT_WIDTH-1:0] w_sum_ext;

  // Extra top bit of the widened sum is the carry out of the accumulator.
  assign w_xfer      = bus.in_valid & (r_state == S_ACCUM);
  assign w_count_inc = r_count + LEN_WIDTH'(1);
  assign w_last      = (w_count_inc == r_len);
  assign w_sum_ext   = EXT_WIDTH'(r_acc) + EXT_WIDTH'(bus.in_data);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_state_nxt = (bus.length == '0) ? S_DONE : S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (w_xfer && w_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.sum_ack) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Status flags track the next state so they line up with r_state each cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_in_ready  <= 1'b0;
      r_sum_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_in_ready  <= (w_state_nxt == S_ACCUM);
      r_sum_valid <= (w_state_nxt == S_DONE);
      r_busy      <= (w_state_nxt != S_IDLE);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_acc   <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_len   <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_acc   <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
            r_len   <= bus.length;
          end
        end
        S_ACCUM: begin
          if (w_xfer) begin
            r_acc   <= w_sum_ext[SUM_WIDTH-1:0];
            r_count <= w_count_inc;
            r_ovf   <= r_ovf | w_sum_ext[SUM_WIDTH];
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.sum_valid = r_sum_valid;
  assign bus.sum_out   = r_acc;
  assign bus.overflow  = r_ovf;
  assign bus.busy      = r_busy;
  assign bus.count     = r_count;

endmodule
